hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator.sv | 83 ++++++++
 tb/tb_hvsync_generator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hvsync_generator.sv
// Video timing generator: free-running pixel/line counters with registered sync pulses.
// Define HVSYNC_POSITIVE_SYNC_EN for active-high hsync/vsync (default is active low).
module hvsync_generator #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_BOTTOM  = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_TOP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos
);

   localparam logic [9:0] HMax       = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] HSyncStart = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HSyncEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VMax       = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
   localparam logic [9:0] VSyncStart = 10'(V_DISPLAY + V_BOTTOM);
   localparam logic [9:0] VSyncEnd   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
   localparam logic [9:0] HDisplay   = 10'(H_DISPLAY);
   localparam logic [9:0] VDisplay   = 10'(V_DISPLAY);

`ifdef HVSYNC_POSITIVE_SYNC_EN
   localparam logic SyncIdle = 1'b0;
`else
   localparam logic SyncIdle = 1'b1;
`endif

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       h_in_sync, v_in_sync;

   always_comb begin
      hpos_d = hpos_q + 10'd1;
      vpos_d = vpos_q;
      if (hpos_q == HMax) begin
         hpos_d = 10'd0;
         vpos_d = (vpos_q == VMax) ? 10'd0 : vpos_q + 10'd1;
      end

      // Sync compares use the pre-edge counters, so the pulses lag the counters by one clock.
      h_in_sync = (hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd);
      v_in_sync = (vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd);
`ifdef HVSYNC_POSITIVE_SYNC_EN
      hsync_d = h_in_sync;
      vsync_d = v_in_sync;
`else
      hsync_d = ~h_in_sync;
      vsync_d = ~v_in_sync;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos_q  <= 10'd0;
         vpos_q  <= 10'd0;
         hsync_q <= SyncIdle;
         vsync_q <= SyncIdle;
      end else begin
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_on = (hpos_q < HDisplay) && (vpos_q < VDisplay);

endmodule

// File: tb/tb_hvsync_generator.sv
// Scoreboard bench for hvsync_generator: full-width lines, shortened frame height.
// Honours HVSYNC_POSITIVE_SYNC_EN for the expected sync polarity.
module tb_hvsync_generator;

   localparam int unsigned HD = 640, HF = 16, HS = 96, HB = 48;
   localparam int unsigned VD = 8, VB = 2, VS = 2, VT = 3;
   localparam int unsigned HTOT  = HD + HF + HS + HB;
   localparam int unsigned VTOT  = VD + VB + VS + VT;
   localparam int unsigned FRAME = HTOT * VTOT;
   localparam int unsigned HSS = HD + HF, HSE = HD + HF + HS - 1;
   localparam int unsigned VSS = VD + VB, VSE = VD + VB + VS - 1;
`ifdef HVSYNC_POSITIVE_SYNC_EN
   localparam logic ACT = 1'b1;
`else
   localparam logic ACT = 1'b0;
`endif
   localparam logic IDLE = !ACT;

   typedef struct packed {
      logic [9:0] hpos;
      logic [9:0] vpos;
      logic       hs;
      logic       vs;
      logic       disp;
      logic       rst;
   } exp_t;

   logic       clk, reset, clk_en;
   logic       hsync, vsync, display_on;
   logic [9:0] hpos, vpos;

   exp_t        q[$];
   event        pushed_ev;
   int unsigned t;
   int unsigned checks, passes;
   int unsigned vs_run, vs_runs_seen;

   hvsync_generator #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hsync     (hsync),
      .vsync     (vsync),
      .display_on(display_on),
      .hpos      (hpos),
      .vpos      (vpos)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Reference: everything follows from the clock count since reset release.
   function automatic exp_t model(int unsigned n);
      exp_t        e;
      int unsigned ph, pv;
      e.hpos = 10'(n % HTOT);
      e.vpos = 10'((n / HTOT) % VTOT);
      e.disp = ((n % HTOT) < HD) && (((n / HTOT) % VTOT) < VD);
      if (n == 0) begin
         e.hs = IDLE;
         e.vs = IDLE;
      end else begin
         ph   = (n - 1) % HTOT;
         pv   = ((n - 1) / HTOT) % VTOT;
         e.hs = (ph >= HSS && ph <= HSE) ? ACT : IDLE;
         e.vs = (pv >= VSS && pv <= VSE) ? ACT : IDLE;
      end
      e.rst = 1'b0;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int unsigned at);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, at, $time);
      else
         passes++;
   endtask

   task automatic push(exp_t e);
      q.push_back(e);
      -> pushed_ev;
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      if (!reset) t++;
      #1;
      e     = model(t);
      e.rst = reset;
      push(e);
   endtask

   // Assert reset between clock edges, check it immediately, hold for some edges.
   task automatic pulse_reset(int unsigned hold);
      exp_t e;
      #2;
      reset = 1'b1;
      t     = 0;
      #1;
      e     = model(0);
      e.rst = 1'b1;
      push(e);
      repeat (hold) step();
      #3;
      reset = 1'b0;
   endtask

   // Monitor: pop and compare each expected sample as it is published.
   initial begin
      exp_t e;
      forever begin
         @(pushed_ev);
         while (q.size() != 0) begin
            e = q.pop_front();
            chk("hpos", 32'(hpos), 32'(e.hpos), t);
            chk("vpos", 32'(vpos), 32'(e.vpos), t);
            chk("hsync", 32'(hsync), 32'(e.hs), t);
            chk("vsync", 32'(vsync), 32'(e.vs), t);
            chk("display_on", 32'(display_on), 32'(e.disp), t);
            if (e.rst) begin
               vs_run = 0;
            end else if (vsync === ACT) begin
               vs_run++;
            end else if (vs_run != 0) begin
               chk("vsync_active_run_len", vs_run, VS * HTOT, t);
               vs_runs_seen++;
               vs_run = 0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      checks = 0; passes = 0; vs_run = 0; vs_runs_seen = 0;
      t = 0; clk_en = 1'b0; reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      e     = model(0);
      e.rst = 1'b1;
      push(e);
      #3 clk_en = 1'b1;
      repeat (2) step();
      #3 reset = 1'b0;

      // Two undisturbed frames plus a little: line wraps, frame wrap, sync windows.
      repeat (2 * FRAME + 100) step();

      // Land a reset in the middle of the vertical sync pulse.
      for (int i = 0; i < FRAME && (t % FRAME) != VSS * HTOT + 300; i++) step();
      pulse_reset(1);

      for (int i = 0; i < 8000; i++) begin
         step();
         if ($urandom_range(0, 799) == 0) pulse_reset($urandom_range(0, 3));
      end

      for (int i = 0; i < 20 && q.size() != 0; i++) #1;
      chk("queue_drain", q.size(), 0, t);
      chk("vsync_runs_observed_ge2", 32'(vs_runs_seen >= 2), 1, t);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
